// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler feeding a UART transmitter.
// REQ0 sends one byte, REQ1 sends a word LSB first; BUSY is tracked per byte.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sched_en,
  input  logic                    req0_valid,
  input  logic [DATA_WIDTH-1:0]   req0_data,
  output logic                    req0_ack,
  input  logic                    req1_valid,
  input  logic [2*DATA_WIDTH-1:0] req1_data,
  output logic                    req1_ack,
  input  logic                    tx_busy,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_data_valid,
  output logic                    sched_busy,
  output logic                    timeout_err
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, SEND, WAIT_HI, WAIT_LO
  } state_t;

  state_t          state, state_nxt;
  logic [2*DW-1:0] hold, hold_nxt;
  logic [DW-1:0]   byte_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            idx, idx_nxt;
  logic            two, two_nxt;
  logic            last1, last1_nxt;
  logic            gnt0, gnt1, tmo;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    idx_nxt   = idx;
    two_nxt   = two;
    last1_nxt = last1;
    cnt_nxt   = cnt;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (sched_en && !tx_busy) begin
          // last1 set means REQ0 wins a tie
          if (req0_valid && (!req1_valid || last1))
            gnt0 = 1'b1;
          else if (req1_valid)
            gnt1 = 1'b1;
        end
        if (gnt0) begin
          hold_nxt  = {{DW{1'b0}}, req0_data};
          two_nxt   = 1'b0;
          last1_nxt = 1'b0;
        end
        if (gnt1) begin
          hold_nxt  = req1_data;
          two_nxt   = 1'b1;
          last1_nxt = 1'b1;
        end
        if (gnt0 || gnt1) begin
          idx_nxt   = 1'b0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_nxt = WAIT_LO;
        end else begin
          cnt_nxt = (cnt == TMO) ? cnt : cnt + CW'(1);
          if (cnt_nxt == TMO) begin
            tmo       = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (two && !idx) begin
            idx_nxt   = 1'b1;
            state_nxt = SEND;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign byte_nxt   = idx_nxt ? hold_nxt[2*DW-1:DW]
                              : hold_nxt[DW-1:0];
  assign sched_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hold          <= '0;
      idx           <= 1'b0;
      two           <= 1'b0;
      last1         <= 1'b1;
      cnt           <= '0;
      req0_ack      <= 1'b0;
      req1_ack      <= 1'b0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold          <= hold_nxt;
      idx           <= idx_nxt;
      two           <= two_nxt;
      last1         <= last1_nxt;
      cnt           <= cnt_nxt;
      req0_ack      <= gnt0;
      req1_ack      <= gnt1;
      tx_data_valid <= (state_nxt == SEND);
      timeout_err   <= tmo;
      if (state_nxt == SEND)
        tx_p_data <= byte_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: queued requesters,
// a reactive UART BUSY model and an output monitor.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sched_en = 1'b0;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = '0;
  logic        req0_ack;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_data = '0;
  logic        req1_ack;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        sched_busy;
  logic        timeout_err;

  uart_tx_scheduler #(.DATA_WIDTH(8), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req1_ack(req1_ack),
    .tx_busy(tx_busy), .tx_p_data(tx_p_data),
    .tx_data_valid(tx_data_valid),
    .sched_busy(sched_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          ack_q[$];
  logic [7:0]  r0_q[$];
  logic [15:0] r1_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          uart_ok = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic exp_byte(input logic [7:0] d);
    exp_t e;
    e.err  = 1'b0;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.err  = 1'b1;
    e.data = '0;
    exp_q.push_back(e);
  endtask

  // UART: BUSY rises 1 cycle after DATA_VALID and stays 11 cycles
  initial begin
    int bcnt = 0;
    bit pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_busy = 1'b0;
        bcnt    = 0;
        pend    = 1'b0;
      end else begin
        if (pend) begin
          pend = 1'b0;
          bcnt = 11;
        end
        if (bcnt > 0) begin
          tx_busy = 1'b1;
          bcnt--;
        end else begin
          tx_busy = 1'b0;
        end
        if (tx_data_valid && uart_ok) pend = 1'b1;
      end
    end
  end

  // requesters hold VALID/data until their ACK is seen
  initial begin
    forever begin
      @(negedge clk);
      if (req0_ack && r0_q.size() > 0) void'(r0_q.pop_front());
      if (req1_ack && r1_q.size() > 0) void'(r1_q.pop_front());
      req0_valid = (r0_q.size() > 0);
      req1_valid = (r1_q.size() > 0);
      if (req0_valid) req0_data = r0_q[0];
      if (req1_valid) req1_data = r1_q[0];
    end
  end

  // monitor
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_data_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_dv", {24'h0, tx_p_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("dv_kind", 32'(e.err), 32'(0));
            check("p_data", {24'h0, tx_p_data}, {24'h0, e.data});
          end
        end
        if (timeout_err) begin
          if (exp_q.size() == 0) begin
            check("unexpected_err", 32'(timeout_err), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("err_kind", 32'(e.err), 32'(1));
          end
        end
        if (req0_ack || req1_ack) begin
          if (ack_q.size() == 0) begin
            check("unexpected_ack", {30'h0, req1_ack, req0_ack}, 32'(0));
          end else begin
            a = ack_q.pop_front();
            check("ack_id", {30'h0, req1_ack, req0_ack},
                  (a == 0) ? 32'd1 : 32'd2);
            check("ack_with_dv", 32'(tx_data_valid), 32'(1));
          end
        end
      end
    end
  end

  task automatic wait_for(input int sel, input int lim,
                          input string nm, output int at);
    bit hit = 1'b0;
    for (int i = 0; i < lim && !hit; i++) begin
      @(negedge clk);
      #1;
      case (sel)
        0: hit = tx_data_valid;
        1: hit = timeout_err;
        2: hit = !tx_busy;
        default: hit = tx_busy;
      endcase
    end
    at = cyc;
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: no event within %0d cycles", nm, lim);
    end
  endtask

  task automatic wait_drain(input int lim, input string nm);
    bit done = 1'b0;
    for (int i = 0; i < lim && !done; i++) begin
      @(negedge clk);
      done = exp_q.size() == 0 && ack_q.size() == 0 &&
             r0_q.size() == 0 && r1_q.size() == 0 &&
             !sched_busy && !tx_busy;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s: not drained, exp=%0d acks=%0d busy=%0b",
               nm, exp_q.size(), ack_q.size(), sched_busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t0, t1, t2;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2;
    repeat (3) @(negedge clk);
    check("rst_sched_busy", 32'(sched_busy), 32'(0));
    check("rst_dv", 32'(tx_data_valid), 32'(0));
    check("rst_p_data", {24'h0, tx_p_data}, 32'(0));
    check("rst_ack0", 32'(req0_ack), 32'(0));
    check("rst_ack1", 32'(req1_ack), 32'(0));
    check("rst_err", 32'(timeout_err), 32'(0));
    rst = 1'b0;
    sched_en = 1'b1;

    // 1: single byte from REQ0
    exp_byte(8'hA5);
    ack_q.push_back(0);
    r0_q.push_back(8'hA5);
    wait_drain(100, "t1_drain");

    // 2: REQ1 word, LSB first, 2nd byte 1 cycle after BUSY falls
    exp_byte(8'h34);
    exp_byte(8'h12);
    ack_q.push_back(1);
    r1_q.push_back(16'h1234);
    wait_for(0, 20, "t2_dv1", t0);
    wait_for(3, 20, "t2_busy_hi", t0);
    wait_for(2, 20, "t2_busy_lo", t1);
    wait_for(0, 20, "t2_dv2", t2);
    check("t2_gap", t2 - t1, 32'(1));
    wait_drain(100, "t2_drain");

    // 3: both requesters from reset alternate strictly
    do_reset();
    exp_byte(8'h11);
    exp_byte(8'hEF);
    exp_byte(8'hBE);
    exp_byte(8'h11);
    exp_byte(8'hEF);
    exp_byte(8'hBE);
    ack_q = '{0, 1, 0, 1};
    r0_q  = '{8'h11, 8'h11};
    r1_q  = '{16'hBEEF, 16'hBEEF};
    wait_drain(400, "t3_drain");

    // 4: BUSY never rises: 4 WAIT_HI cycles, ERR pulse the cycle after
    uart_ok = 1'b0;
    exp_byte(8'hFE);
    exp_err();
    ack_q.push_back(1);
    r1_q.push_back(16'hCAFE);
    wait_for(0, 20, "t4_dv", t0);
    wait_for(1, 20, "t4_err", t1);
    check("t4_err_lat", t1 - t0, 32'(5));
    wait_drain(100, "t4_drain");
    repeat (20) @(negedge clk);
    uart_ok = 1'b1;

    // 5: reset during WAIT_LO of the first REQ1 byte
    exp_byte(8'h34);
    ack_q.push_back(1);
    r1_q.push_back(16'h1234);
    wait_for(3, 20, "t5_busy_hi", t0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_sched_busy", 32'(sched_busy), 32'(0));
    check("t5_dv", 32'(tx_data_valid), 32'(0));
    check("t5_p_data", {24'h0, tx_p_data}, 32'(0));
    check("t5_exp_left", exp_q.size(), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_byte(8'h34);
    exp_byte(8'h12);
    ack_q.push_back(1);
    r1_q.push_back(16'h1234);
    wait_drain(100, "t5_drain");

    // 6: SCHED_EN gates grants, but not an in-flight frame
    sched_en = 1'b0;
    r0_q.push_back(8'h5A);
    repeat (6) @(negedge clk);
    check("t6_held_busy", 32'(sched_busy), 32'(0));
    exp_byte(8'h5A);
    ack_q.push_back(0);
    sched_en = 1'b1;
    @(negedge clk);
    check("t6_grant", 32'(sched_busy), 32'(1));
    wait_drain(100, "t6a_drain");
    exp_byte(8'h78);
    exp_byte(8'h56);
    ack_q.push_back(1);
    r1_q.push_back(16'h5678);
    wait_for(0, 20, "t6_dv1", t0);
    sched_en = 1'b0;
    wait_drain(100, "t6b_drain");
    sched_en = 1'b1;

    repeat (5) @(negedge clk);
    check("final_exp_left", exp_q.size(), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
